fb_write_arbiter: RTL and testbench

Sequences and shares the single write port of the 320x240, 3-bit-per-pixel VGA framebuffer between two requesters: a CPU store port (single-pixel writes) and a built-in rectangle-fill engine (clear screen, draw boxes). It sits between the processor's memory-mapped I/O and the VGA block's `wr_en`/`wr_addr`/`wr_data` inputs. It guarantees at most one write per cycle, a fair share of bandwidth to each requester, and no write outside the 76800-pixel buffer.

---
 rtl/fb_pkg.sv | 40 ++++
 rtl/fb_write_arbiter_if.sv | 45 ++++
 rtl/fb_fill_engine.sv | 129 ++++++++++++
 rtl/fb_write_arbiter.sv | 96 +++++++++
 tb/tb_fb_write_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fb_pkg
//  Description : Shared framebuffer geometry, pixel/address types, fill-state
//                encoding and small arithmetic helpers for the write arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package fb_pkg;

   localparam int FB_W      = 320;
   localparam int FB_H      = 240;
   localparam int FB_PIXELS = FB_W * FB_H;
   localparam int ADDR_W    = 17;
   localparam int COLOR_W   = 3;

   typedef logic [COLOR_W-1:0] color_t;
   typedef logic [ADDR_W-1:0]  addr_t;

   typedef enum logic [0:0] {
      FILL_IDLE = 1'b0,
      FILL_RUN  = 1'b1
   } fill_state_t;

   // Exclusive end coordinate of a span, clamped to the screen edge.
   // Ten bits hold start+size for both axes without wrapping.
   function automatic logic [9:0] clip_end(input logic [9:0] start,
                                           input logic [9:0] size,
                                           input logic [9:0] limit);
      logic [9:0] sum;
      sum = start + size;
      return (sum > limit) ? limit : sum;
   endfunction

   // row * 320 as two shifts (256 + 64); used once per fill start.
   function automatic addr_t row_offset(input logic [7:0] row);
      return (addr_t'(row) << 8) + (addr_t'(row) << 6);
   endfunction

endpackage
`default_nettype wire

// File: rtl/fb_write_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : fb_write_arbiter_if
//  Description : Bundles the CPU store port, the fill command port and the
//                framebuffer write port of the arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fb_write_arbiter_if;
   import fb_pkg::*;

   logic       cpu_req;
   addr_t      cpu_addr;
   color_t     cpu_data;
   logic       cpu_ack;

   logic       fill_start;
   logic [8:0] fill_x;
   logic [7:0] fill_y;
   logic [8:0] fill_w;
   logic [7:0] fill_h;
   color_t     fill_color;
   logic       fill_busy;
   logic       fill_done;

   logic       err;
   logic       wr_en;
   addr_t      wr_addr;
   color_t     wr_data;

   // Requester side: drives the CPU and fill commands, observes the results.
   modport master (
      output cpu_req, cpu_addr, cpu_data,
      output fill_start, fill_x, fill_y, fill_w, fill_h, fill_color,
      input  cpu_ack, fill_busy, fill_done, err, wr_en, wr_addr, wr_data
   );

   // Arbiter side.
   modport slave (
      input  cpu_req, cpu_addr, cpu_data,
      input  fill_start, fill_x, fill_y, fill_w, fill_h, fill_color,
      output cpu_ack, fill_busy, fill_done, err, wr_en, wr_addr, wr_data
   );

endinterface
`default_nettype wire

// File: rtl/fb_fill_engine.sv
`default_nettype none
// ============================================================================
//  Module      : fb_fill_engine
//  Description : Rectangle-fill engine. Clips the requested box to the
//                screen, then walks it row by row producing one pixel
//                address per grant using incremental address arithmetic.
//  Revision    : 1.0 - initial release
// ============================================================================
module fb_fill_engine
   import fb_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [8:0]  x,
   input  logic [7:0]  y,
   input  logic [8:0]  w,
   input  logic [7:0]  h,
   input  color_t      color,
   input  logic        grant,
   output logic        req,
   output addr_t       addr,
   output color_t      data,
   output logic        last,
   output logic        busy,
   output logic        skip
);

   localparam logic [9:0] c_fb_w10 = 10'(FB_W);
   localparam logic [9:0] c_fb_h10 = 10'(FB_H);
   localparam addr_t      c_row_step = addr_t'(FB_W);

   fill_state_t r_state;
   fill_state_t w_state_next;

   logic [8:0]  r_x0;
   logic [8:0]  r_x_last;
   logic [7:0]  r_y_last;
   logic [8:0]  r_cur_x;
   logic [7:0]  r_cur_y;
   addr_t       r_row_base;
   addr_t       r_addr;
   color_t      r_color;
   logic        r_skip;

   logic [9:0]  w_x_end;
   logic [9:0]  w_y_end;
   logic        w_degenerate;
   logic        w_accept;
   logic        w_step;
   logic        w_row_end;
   logic        w_at_last;

   assign w_x_end      = clip_end({1'b0, x}, {1'b0, w}, c_fb_w10);
   assign w_y_end      = clip_end({2'b00, y}, {2'b00, h}, c_fb_h10);
   assign w_degenerate = (w == 9'd0) || (h == 8'd0) ||
                         ({1'b0, x} >= c_fb_w10) || ({2'b00, y} >= c_fb_h10);
   assign w_accept     = (r_state == FILL_IDLE) && start;
   assign w_step       = (r_state == FILL_RUN) && grant;
   assign w_row_end    = (r_cur_x == r_x_last);
   assign w_at_last    = w_row_end && (r_cur_y == r_y_last);

   // Fill state register.
   always_ff @(posedge clock) begin
      if (!reset) r_state <= FILL_IDLE;
      else        r_state <= w_state_next;
   end

   // Next state: start only non-empty boxes, finish on the last granted pixel.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         FILL_IDLE: if (start && !w_degenerate) w_state_next = FILL_RUN;
         FILL_RUN:  if (w_step && w_at_last)    w_state_next = FILL_IDLE;
         default:   w_state_next = FILL_IDLE;
      endcase
   end

   // State-derived outputs.
   always_comb begin
      req  = (r_state == FILL_RUN);
      busy = (r_state == FILL_RUN);
      last = (r_state == FILL_RUN) && w_at_last;
   end

   // Capture the clipped box at start, then advance coordinates per grant.
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_x0       <= '0;
         r_x_last   <= '0;
         r_y_last   <= '0;
         r_cur_x    <= '0;
         r_cur_y    <= '0;
         r_row_base <= '0;
         r_addr     <= '0;
         r_color    <= '0;
         r_skip     <= 1'b0;
      end else begin
         // An empty box completes immediately without ever going busy.
         r_skip <= w_accept && w_degenerate;
         if (w_accept) begin
            r_x0       <= x;
            r_x_last   <= 9'(w_x_end - 10'd1);
            r_y_last   <= 8'(w_y_end - 10'd1);
            r_cur_x    <= x;
            r_cur_y    <= y;
            r_row_base <= row_offset(y);
            r_addr     <= row_offset(y) + addr_t'(x);
            r_color    <= color;
         end else if (w_step && !w_at_last) begin
            if (w_row_end) begin
               r_cur_x    <= r_x0;
               r_cur_y    <= r_cur_y + 8'd1;
               r_row_base <= r_row_base + c_row_step;
               r_addr     <= r_row_base + c_row_step + addr_t'(r_x0);
            end else begin
               r_cur_x <= r_cur_x + 9'd1;
               r_addr  <= r_addr + addr_t'(1);
            end
         end
      end
   end

   assign addr = r_addr;
   assign data = r_color;
   assign skip = r_skip;

endmodule
`default_nettype wire

// File: rtl/fb_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : fb_write_arbiter
//  Description : Shares the single framebuffer write port between CPU stores
//                and the rectangle-fill engine, alternating under contention
//                and dropping out-of-range CPU stores with an error pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module fb_write_arbiter
   import fb_pkg::*;
(
   input  logic               clock,
   input  logic               reset,
   fb_write_arbiter_if.slave  bus
);

   localparam addr_t c_pixels = addr_t'(FB_PIXELS);

   logic   w_fill_req;
   logic   w_fill_last;
   logic   w_fill_skip;
   addr_t  w_fill_addr;
   color_t w_fill_data;

   logic   w_cpu_grant;
   logic   w_fill_grant;
   logic   w_cpu_in_range;

   logic   r_cpu_won_last;
   logic   r_wr_en;
   addr_t  r_wr_addr;
   color_t r_wr_data;
   logic   r_err;
   logic   r_last_written;

   fb_fill_engine u_fill (
      .clock (clock),
      .reset (reset),
      .start (bus.fill_start),
      .x     (bus.fill_x),
      .y     (bus.fill_y),
      .w     (bus.fill_w),
      .h     (bus.fill_h),
      .color (bus.fill_color),
      .grant (w_fill_grant),
      .req   (w_fill_req),
      .addr  (w_fill_addr),
      .data  (w_fill_data),
      .last  (w_fill_last),
      .busy  (bus.fill_busy),
      .skip  (w_fill_skip)
   );

   // Grant selection: under contention the side that lost the previous
   // grant wins. Nothing is granted while reset is held, so a request
   // presented during reset is never acked without being written.
   always_comb begin
      w_cpu_in_range = (bus.cpu_addr < c_pixels);
      w_cpu_grant    = reset && bus.cpu_req && (!w_fill_req || !r_cpu_won_last);
      w_fill_grant   = reset && w_fill_req && !w_cpu_grant;
   end

   // Register the granted write, the error pulse and the arbitration history.
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_cpu_won_last <= 1'b0;
         r_wr_en        <= 1'b0;
         r_wr_addr      <= '0;
         r_wr_data      <= '0;
         r_err          <= 1'b0;
         r_last_written <= 1'b0;
      end else begin
         r_wr_en        <= (w_cpu_grant && w_cpu_in_range) || w_fill_grant;
         r_err          <= w_cpu_grant && !w_cpu_in_range;
         r_last_written <= w_fill_grant && w_fill_last;
         if (w_cpu_grant) begin
            r_cpu_won_last <= 1'b1;
            r_wr_addr      <= bus.cpu_addr;
            r_wr_data      <= bus.cpu_data;
         end else if (w_fill_grant) begin
            r_cpu_won_last <= 1'b0;
            r_wr_addr      <= w_fill_addr;
            r_wr_data      <= w_fill_data;
         end
      end
   end

   assign bus.cpu_ack   = w_cpu_grant;
   assign bus.wr_en     = r_wr_en;
   assign bus.wr_addr   = r_wr_addr;
   assign bus.wr_data   = r_wr_data;
   assign bus.err       = r_err;
   assign bus.fill_done = r_last_written || w_fill_skip;

endmodule
`default_nettype wire

// File: tb/tb_fb_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fb_write_arbiter
//  Description : Self-checking bench for fb_write_arbiter: a pixel-queue
//                reference model compared every cycle, plus directed
//                scenarios with hand-computed expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fb_write_arbiter;
   import fb_pkg::*;

   logic clock = 1'b0;
   logic reset;

   fb_write_arbiter_if bus ();

   fb_write_arbiter dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model state ----------------
   int     m_pix[$];         // addresses still to be written by the current fill
   color_t m_color;
   bit     m_cpu_last = 0;   // CPU took the most recent grant
   bit     m_ack = 0;        // model's grant to the CPU in the last cycle
   bit     e_wr_en = 0, e_err = 0, e_done = 0, e_busy = 0;
   int     e_addr = 0, e_data = 0;
   int     cyc = 0;
   int     cpu_wait = 0;

   // observation logs for directed scenarios
   int w_cyc[$], w_addr[$], w_data[$];
   int done_cycles[$];
   int err_cnt = 0, busy_cnt = 0;

   // Compare DUT against the model, then advance the model by one cycle.
   always @(negedge clock) begin
      bit g_cpu, g_fill, idle_before;
      int xe, ye;
      #2;
      cyc++;
      chk("wr_en", bus.wr_en, e_wr_en);
      if (e_wr_en) begin
         chk("wr_addr", bus.wr_addr, e_addr);
         chk("wr_data", bus.wr_data, e_data);
      end
      chk("err", bus.err, e_err);
      chk("fill_done", bus.fill_done, e_done);
      chk("fill_busy", bus.fill_busy, e_busy);

      if (bus.wr_en === 1'b1) begin
         w_cyc.push_back(cyc);
         w_addr.push_back(int'(bus.wr_addr));
         w_data.push_back(int'(bus.wr_data));
      end
      if (bus.fill_done === 1'b1) done_cycles.push_back(cyc);
      if (bus.err === 1'b1) err_cnt++;
      if (bus.fill_busy === 1'b1) busy_cnt++;

      g_cpu = 0;
      g_fill = 0;
      if (reset !== 1'b1) begin
         chk("cpu_ack_in_reset", bus.cpu_ack, 0);
         m_pix.delete();
         m_cpu_last = 0;
         e_wr_en = 0; e_err = 0; e_done = 0; e_busy = 0;
         cpu_wait = 0;
      end else begin
         idle_before = (m_pix.size() == 0);
         g_cpu  = bus.cpu_req && (idle_before || !m_cpu_last);
         g_fill = !idle_before && !g_cpu;
         chk("cpu_ack", bus.cpu_ack, g_cpu);
         e_wr_en = 0; e_err = 0; e_done = 0;
         if (g_cpu) begin
            m_cpu_last = 1;
            if (int'(bus.cpu_addr) < FB_PIXELS) begin
               e_wr_en = 1;
               e_addr  = int'(bus.cpu_addr);
               e_data  = int'(bus.cpu_data);
            end else begin
               e_err = 1;
            end
         end else if (g_fill) begin
            m_cpu_last = 0;
            e_wr_en = 1;
            e_addr  = m_pix.pop_front();
            e_data  = int'(m_color);
            if (m_pix.size() == 0) e_done = 1;
         end
         if (idle_before && bus.fill_start) begin
            xe = int'(bus.fill_x) + int'(bus.fill_w);
            if (xe > FB_W) xe = FB_W;
            ye = int'(bus.fill_y) + int'(bus.fill_h);
            if (ye > FB_H) ye = FB_H;
            for (int yy = int'(bus.fill_y); yy < ye; yy++)
               for (int xx = int'(bus.fill_x); xx < xe; xx++)
                  m_pix.push_back(yy * FB_W + xx);
            m_color = bus.fill_color;
            if (m_pix.size() == 0) e_done = 1;
         end
         e_busy = (m_pix.size() != 0);
         if (bus.cpu_req && !g_cpu) cpu_wait++;
         else cpu_wait = 0;
         if (cpu_wait > 0) chk("cpu_ack_latency_over_2", cpu_wait > 1, 0);
      end
      m_ack = g_cpu;
   end

   // ---------------- CPU requester ----------------
   int     cpu_mode = 0;     // 0 off, 1 continuous, 2 random, 3 one-shot
   bit     shot_pend = 0;
   int     shot_addr = 0;
   int     shot_data = 0;

   always @(negedge clock) begin
      if (!(bus.cpu_req && !m_ack)) begin
         bus.cpu_req = 1'b0;
         if (cpu_mode == 1 || (cpu_mode == 2 && $urandom_range(0, 2) == 0)) begin
            bus.cpu_req  = 1'b1;
            bus.cpu_addr = ($urandom_range(0, 15) == 0) ? addr_t'($urandom_range(76800, 131071))
                                                        : addr_t'($urandom_range(0, 76799));
            bus.cpu_data = color_t'($urandom);
         end else if (cpu_mode == 3 && shot_pend) begin
            bus.cpu_req  = 1'b1;
            bus.cpu_addr = addr_t'(shot_addr);
            bus.cpu_data = color_t'(shot_data);
            shot_pend    = 0;
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic clear_logs();
      w_cyc.delete(); w_addr.delete(); w_data.delete();
      done_cycles.delete();
      err_cnt = 0;
      busy_cnt = 0;
   endtask

   task automatic start_fill(input int x, input int y, input int w, input int h,
                             input int c, output int s);
      @(negedge clock);
      bus.fill_x = 9'(x); bus.fill_y = 8'(y);
      bus.fill_w = 9'(w); bus.fill_h = 8'(h);
      bus.fill_color = color_t'(c);
      bus.fill_start = 1'b1;
      #3 s = cyc;
      @(negedge clock);
      bus.fill_start = 1'b0;
      bus.fill_x = 9'($urandom); bus.fill_y = 8'($urandom);
      bus.fill_w = 9'($urandom); bus.fill_h = 8'($urandom);
      bus.fill_color = color_t'($urandom);
   endtask

   task automatic expect_writes(input string name, input int addrs[$], input int color,
                                input int s);
      chk({name, "_count"}, w_addr.size(), addrs.size());
      for (int i = 0; i < addrs.size(); i++) begin
         chk({name, "_addr"}, (i < w_addr.size()) ? w_addr[i] : -1, addrs[i]);
         chk({name, "_data"}, (i < w_data.size()) ? w_data[i] : -1, color);
         chk({name, "_cycle"}, (i < w_cyc.size()) ? w_cyc[i] : -1, s + 2 + i);
      end
      chk({name, "_done_count"}, done_cycles.size(), 1);
      chk({name, "_done_cycle"}, (done_cycles.size() > 0) ? done_cycles[0] : -1,
          s + 1 + addrs.size());
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int s;
      int exp_a[$];
      reset = 1'b0;
      bus.cpu_req = 1'b0; bus.cpu_addr = '0; bus.cpu_data = '0;
      bus.fill_start = 1'b0; bus.fill_x = '0; bus.fill_y = '0;
      bus.fill_w = '0; bus.fill_h = '0; bus.fill_color = '0;

      repeat (3) @(negedge clock);
      #3;
      chk("reset_wr_en", bus.wr_en, 0);
      chk("reset_err", bus.err, 0);
      chk("reset_fill_busy", bus.fill_busy, 0);
      chk("reset_fill_done", bus.fill_done, 0);
      chk("reset_cpu_ack", bus.cpu_ack, 0);
      @(negedge clock) reset = 1'b1;
      repeat (2) @(negedge clock);

      // single in-range CPU write
      #3 clear_logs();
      shot_addr = 100; shot_data = 5; shot_pend = 1; cpu_mode = 3;
      repeat (6) @(negedge clock);
      #3;
      chk("cpu1_count", w_addr.size(), 1);
      chk("cpu1_addr", (w_addr.size() > 0) ? w_addr[0] : -1, 100);
      chk("cpu1_data", (w_data.size() > 0) ? w_data[0] : -1, 5);
      chk("cpu1_err", err_cnt, 0);

      // out-of-range CPU write
      clear_logs();
      shot_addr = 76800; shot_data = 7; shot_pend = 1;
      repeat (6) @(negedge clock);
      #3;
      chk("cpu_oor_count", w_addr.size(), 0);
      chk("cpu_oor_err", err_cnt, 1);
      cpu_mode = 0;

      // uncontended fill
      clear_logs();
      start_fill(2, 1, 3, 2, 4, s);
      repeat (8) @(negedge clock);
      #3;
      exp_a = '{322, 323, 324, 642, 643, 644};
      expect_writes("fill_basic", exp_a, 4, s);

      // fill clipped at the bottom-right corner
      clear_logs();
      start_fill(318, 239, 5, 5, 2, s);
      repeat (6) @(negedge clock);
      #3;
      exp_a = '{76798, 76799};
      expect_writes("fill_clip", exp_a, 2, s);

      // degenerate fills: zero width, then x off-screen
      clear_logs();
      start_fill(10, 10, 0, 4, 1, s);
      repeat (4) @(negedge clock);
      #3;
      chk("degen_w_writes", w_addr.size(), 0);
      chk("degen_w_done_cycle", (done_cycles.size() > 0) ? done_cycles[0] : -1, s + 1);
      chk("degen_w_busy", busy_cnt, 0);
      clear_logs();
      start_fill(320, 10, 4, 4, 1, s);
      repeat (4) @(negedge clock);
      #3;
      chk("degen_x_writes", w_addr.size(), 0);
      chk("degen_x_done_count", done_cycles.size(), 1);
      chk("degen_x_done_cycle", (done_cycles.size() > 0) ? done_cycles[0] : -1, s + 1);
      chk("degen_x_busy", busy_cnt, 0);

      // full-screen fill under continuous CPU traffic, then reset mid-fill
      clear_logs();
      cpu_mode = 1;
      start_fill(0, 0, 320, 240, 6, s);
      repeat (200) @(negedge clock);
      reset = 1'b0;
      cpu_mode = 0;
      @(negedge clock);
      #3;
      chk("rst_mid_wr_en", bus.wr_en, 0);
      chk("rst_mid_busy", bus.fill_busy, 0);
      chk("rst_mid_done", bus.fill_done, 0);
      chk("rst_mid_err", bus.err, 0);
      reset = 1'b1;
      repeat (10) @(negedge clock);
      #3;
      chk("rst_mid_no_done", done_cycles.size(), 0);
      chk("rst_mid_writes_seen", w_addr.size() > 150, 1);
      clear_logs();
      start_fill(5, 5, 2, 2, 1, s);
      repeat (6) @(negedge clock);
      #3;
      exp_a = '{1605, 1606, 1925, 1926};
      expect_writes("fill_after_rst", exp_a, 1, s);

      // randomized traffic
      cpu_mode = 2;
      for (int i = 0; i < 4000; i++) begin
         @(negedge clock);
         reset          = ($urandom_range(0, 399) != 0);
         bus.fill_start = ($urandom_range(0, 15) == 0);
         bus.fill_x     = 9'($urandom_range(0, 330));
         bus.fill_y     = 8'($urandom_range(0, 250));
         bus.fill_w     = 9'(($urandom_range(0, 7) == 0) ? $urandom_range(0, 40) : $urandom_range(0, 12));
         bus.fill_h     = 8'($urandom_range(0, 6));
         bus.fill_color = color_t'($urandom);
      end
      @(negedge clock);
      reset = 1'b1;
      bus.fill_start = 1'b0;
      cpu_mode = 0;
      repeat (600) @(negedge clock);
      #3;
      chk("drain_busy", bus.fill_busy, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
